// File: rtl/display_scanner_pkg.sv
// Shared definitions for the display scanner.
// Holds the slot numbering of the multiplexed panel, the bit positions of the
// annunciator byte, the scan sequencer state encoding, and a helper that packs
// the annunciator flags into their panel byte.
package display_scanner_pkg;

    localparam int NUM_SLOTS = 7;

    // Panel slots, in scan order.
    localparam logic [2:0] SLOT_U10   = 3'd0;
    localparam logic [2:0] SLOT_U01   = 3'd1;
    localparam logic [2:0] SLOT_L1000 = 3'd2;
    localparam logic [2:0] SLOT_L0100 = 3'd3;
    localparam logic [2:0] SLOT_L0010 = 3'd4;
    localparam logic [2:0] SLOT_L0001 = 3'd5;
    localparam logic [2:0] SLOT_ANN   = 3'd6;

    // Annunciator byte bit positions; bits 7:6 are always zero.
    localparam int ANN_AVS   = 0;
    localparam int ANN_DAY   = 1;
    localparam int ANN_MAX   = 2;
    localparam int ANN_TIM   = 3;
    localparam int ANN_COL   = 4;
    localparam int ANN_POINT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    function automatic logic [7:0] pack_ann(
        input logic avs_f,
        input logic day_f,
        input logic max_f,
        input logic tim_f,
        input logic col_f,
        input logic point_f
    );
        logic [7:0] ann_b;
        ann_b            = 8'h00;
        ann_b[ANN_AVS]   = avs_f;
        ann_b[ANN_DAY]   = day_f;
        ann_b[ANN_MAX]   = max_f;
        ann_b[ANN_TIM]   = tim_f;
        ann_b[ANN_COL]   = col_f;
        ann_b[ANN_POINT] = point_f;
        return ann_b;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Display data bundle from the control block to the scanner.
// Carries the six 8-bit segment patterns (1 = lit) and the six annunciator flags.
// master: the producer (control block); slave: the consumer (display_scanner).
interface display_scanner_if;

    logic [7:0] upper10;
    logic [7:0] upper01;
    logic [7:0] lower1000;
    logic [7:0] lower0100;
    logic [7:0] lower0010;
    logic [7:0] lower0001;
    logic       AVS;
    logic       DAY;
    logic       MAX;
    logic       TIM;
    logic       col;
    logic       point;

    modport master (
        output upper10, upper01, lower1000, lower0100, lower0010, lower0001,
        output AVS, DAY, MAX, TIM, col, point
    );

    modport slave (
        input upper10, upper01, lower1000, lower0100, lower0010, lower0001,
        input AVS, DAY, MAX, TIM, col, point
    );

endinterface

// File: rtl/display_scanner_scan_timer.sv
// Slot sequencer for the display scanner.
// Walks IDLE -> (BLANK -> ON) x 7 slots -> wrap, counting ticks in each phase.
// Ports:
//   clock, reset (sync, active-low), en (scan enable)
//   phase_s, slot_s, on_tick_s, wrap_s: the phase, slot, in-phase tick and
//     snapshot-load strobe that the sequencer takes on at the coming clock edge.
//     They are exported one edge early so the top can register its outputs in
//     the same edge as the sequencer state, keeping everything cycle-aligned.
module scan_timer
    import display_scanner_pkg::*;
#(
    parameter int DIGIT_TICKS = 16,
    parameter int BLANK_TICKS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output scan_state_e phase_s,
    output logic [2:0]  slot_s,
    output logic [7:0]  on_tick_s,
    output logic        wrap_s
);

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS - 1);
    localparam logic [7:0] ON_LAST    = 8'(DIGIT_TICKS - BLANK_TICKS - 1);

    scan_state_e phase_r;
    logic [2:0]  slot_r;
    logic [7:0]  tick_r;

    // Next-state decode; the tick counter restarts at 0 on every phase change.
    always_comb begin
        phase_s = phase_r;
        slot_s  = slot_r;
        on_tick_s = tick_r;
        wrap_s  = 1'b0;
        if (!en) begin
            phase_s   = IDLE;
            slot_s    = SLOT_U10;
            on_tick_s = 8'd0;
        end else begin
            case (phase_r)
                IDLE: begin
                    phase_s   = BLANK;
                    slot_s    = SLOT_U10;
                    on_tick_s = 8'd0;
                    wrap_s    = 1'b1;
                end
                BLANK: begin
                    if (tick_r == BLANK_LAST) begin
                        phase_s   = ON;
                        on_tick_s = 8'd0;
                    end else begin
                        on_tick_s = tick_r + 8'd1;
                    end
                end
                ON: begin
                    if (tick_r == ON_LAST) begin
                        phase_s   = BLANK;
                        on_tick_s = 8'd0;
                        if (slot_r == SLOT_ANN) begin
                            slot_s = SLOT_U10;
                            wrap_s = 1'b1;
                        end else begin
                            slot_s = slot_r + 3'd1;
                        end
                    end else begin
                        on_tick_s = tick_r + 8'd1;
                    end
                end
                default: begin
                    phase_s   = IDLE;
                    slot_s    = SLOT_U10;
                    on_tick_s = 8'd0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_r <= IDLE;
            slot_r  <= SLOT_U10;
            tick_r  <= 8'd0;
        end else begin
            phase_r <= phase_s;
            slot_r  <= slot_s;
            tick_r  <= on_tick_s;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed LED panel scanner.
// Snapshots the control block's display data once per frame and scans it out
// one slot at a time on a shared segment bus with a one-hot digit select,
// inserting a blank gap before every slot and optionally halving brightness.
// Ports:
//   clock, reset (sync, active-low), en (scan enable), dim (half brightness)
//   disp        display data bundle (slave side)
//   seg_out     shared segment bus, polarity per SEG_ACTIVE_LOW
//   dig_sel     one-hot digit select, polarity per DIG_ACTIVE_LOW
//   slot_idx    current slot 0..6
//   frame_start one-cycle pulse in the cycle the snapshot is loaded
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIGIT_TICKS    = 16,
    parameter int BLANK_TICKS    = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                dim,
    display_scanner_if.slave    disp,
    output logic [7:0]          seg_out,
    output logic [6:0]          dig_sel,
    output logic [2:0]          slot_idx,
    output logic                frame_start
);

    localparam int         ON_TICKS  = DIGIT_TICKS - BLANK_TICKS;
    localparam logic [7:0] DIM_LIMIT = 8'(ON_TICKS / 2);
    localparam logic [7:0] SEG_POL   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [6:0] DIG_POL   = (DIG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    scan_state_e phase_s;
    logic [2:0]  slot_s;
    logic [7:0]  on_tick_s;
    logic        wrap_s;
    logic        lit_s;
    logic [7:0]  seg_nxt_s;
    logic [6:0]  dig_nxt_s;

    logic [7:0]  snap_r [NUM_SLOTS];
    logic [7:0]  seg_out_r;
    logic [6:0]  dig_sel_r;
    logic [2:0]  slot_idx_r;
    logic        frame_start_r;

    scan_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_scan_timer (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .phase_s   (phase_s),
        .slot_s    (slot_s),
        .on_tick_s (on_tick_s),
        .wrap_s    (wrap_s)
    );

    // Decide whether the coming cycle lights a digit; dim keeps only the first half of ON.
    always_comb begin
        lit_s = 1'b0;
        if (phase_s == ON) begin
            if (dim && (on_tick_s >= DIM_LIMIT)) begin
                lit_s = 1'b0;
            end else begin
                lit_s = 1'b1;
            end
        end else begin
            lit_s = 1'b0;
        end
    end

    // Output mux with polarity; segment and digit select are lit together or not at all.
    always_comb begin
        seg_nxt_s = SEG_POL;
        dig_nxt_s = DIG_POL;
        if (lit_s) begin
            seg_nxt_s = snap_r[slot_s] ^ SEG_POL;
            dig_nxt_s = (7'd1 << slot_s) ^ DIG_POL;
        end else begin
            seg_nxt_s = SEG_POL;
            dig_nxt_s = DIG_POL;
        end
    end

    // Frame snapshot; reloaded only on the wrap strobe so a frame never tears.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                snap_r[i] <= 8'h00;
            end
        end else if (wrap_s) begin
            snap_r[SLOT_U10]   <= disp.upper10;
            snap_r[SLOT_U01]   <= disp.upper01;
            snap_r[SLOT_L1000] <= disp.lower1000;
            snap_r[SLOT_L0100] <= disp.lower0100;
            snap_r[SLOT_L0010] <= disp.lower0010;
            snap_r[SLOT_L0001] <= disp.lower0001;
            snap_r[SLOT_ANN]   <= pack_ann(disp.AVS, disp.DAY, disp.MAX,
                                           disp.TIM, disp.col, disp.point);
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                snap_r[i] <= snap_r[i];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seg_out_r     <= SEG_POL;
            dig_sel_r     <= DIG_POL;
            slot_idx_r    <= SLOT_U10;
            frame_start_r <= 1'b0;
        end else begin
            seg_out_r     <= seg_nxt_s;
            dig_sel_r     <= dig_nxt_s;
            slot_idx_r    <= slot_s;
            frame_start_r <= wrap_s;
        end
    end

    assign seg_out     = seg_out_r;
    assign dig_sel     = dig_sel_r;
    assign slot_idx    = slot_idx_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (default parameters).
// A cycle model built on a single frame-position counter predicts every output
// cycle; predictions are queued when stimulus is applied and compared when the
// DUT output is sampled on the falling edge. Directed checks cover the
// documented scenarios.
module tb_display_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       dim   = 1'b0;
    logic [7:0] seg_out;
    logic [6:0] dig_sel;
    logic [2:0] slot_idx;
    logic       frame_start;

    display_scanner_if dif ();

    display_scanner dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .dim         (dim),
        .disp        (dif.slave),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .slot_idx    (slot_idx),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // model state
    logic        m_active = 1'b0;
    int          m_pos    = 0;
    logic [7:0]  m_snap [7];
    logic [18:0] sb_q [$];

    // observation bookkeeping
    logic [7:0] obs_seg;
    logic [6:0] obs_dig;
    logic [2:0] obs_slot;
    logic       obs_fs;
    int         cyc         = 0;
    int         last_fs     = -1;
    int         last_period = 0;
    int         lit_cnt     = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Predict the outputs that the coming clock edge will produce.
    task automatic model_step();
        logic [7:0] seg;
        logic [6:0] dig;
        logic [2:0] slot;
        logic       fs;
        logic       lit;
        int         ph;
        seg  = 8'hFF;
        dig  = 7'h00;
        slot = 3'd0;
        fs   = 1'b0;
        if (!reset) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!en) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_pos = (m_pos + 1) % 112;
            end
            if (m_pos == 0) begin
                m_snap[0] = dif.upper10;
                m_snap[1] = dif.upper01;
                m_snap[2] = dif.lower1000;
                m_snap[3] = dif.lower0100;
                m_snap[4] = dif.lower0010;
                m_snap[5] = dif.lower0001;
                m_snap[6] = {2'b00, dif.point, dif.col, dif.TIM, dif.MAX, dif.DAY, dif.AVS};
            end
            slot = 3'(m_pos / 16);
            ph   = m_pos % 16;
            lit  = (ph >= 2) && (!dim || (ph - 2) < 7);
            if (lit) begin
                seg = ~m_snap[slot];
                dig = 7'(1 << slot);
            end
            fs = (m_pos == 0);
        end
        sb_q.push_back({seg, dig, slot, fs});
    endtask

    // One clock cycle: predict, clock, sample, compare.
    task automatic step();
        logic [18:0] exp_v;
        model_step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        obs_seg  = seg_out;
        obs_dig  = dig_sel;
        obs_slot = slot_idx;
        obs_fs   = frame_start;
        check_val("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check_val("cycle", {13'd0, obs_seg, obs_dig, obs_slot, obs_fs}, {13'd0, exp_v});
        end
        if (obs_dig != 7'h00) lit_cnt++;
        if (obs_fs) begin
            if (last_fs >= 0) last_period = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    // Step until the model reaches frame position p (bounded).
    task automatic run_to(input int p);
        for (int n = 0; n < 300; n++) begin
            step();
            if (m_active && m_pos == p) break;
        end
        check_val("run_to", 32'(m_pos), 32'(p));
    endtask

    initial begin
        dif.upper10   = 8'h3F;
        dif.upper01   = 8'h06;
        dif.lower1000 = 8'h5B;
        dif.lower0100 = 8'h4F;
        dif.lower0010 = 8'h66;
        dif.lower0001 = 8'h06;
        dif.AVS = 1'b1; dif.DAY = 1'b0; dif.MAX = 1'b0;
        dif.TIM = 1'b0; dif.col = 1'b1; dif.point = 1'b1;
        en = 1'b1;

        // reset state
        repeat (3) step();
        check_val("rst_seg",  32'(obs_seg),  32'h0000_00FF);
        check_val("rst_dig",  32'(obs_dig),  32'h0000_0000);
        check_val("rst_slot", 32'(obs_slot), 32'h0000_0000);
        check_val("rst_fs",   32'(obs_fs),   32'h0000_0000);

        // first frame after release
        reset = 1'b1;
        step();
        check_val("fs_first",    32'(obs_fs),  32'd1);
        check_val("blank0_dig",  32'(obs_dig), 32'h00);
        step();
        check_val("blank1_seg",  32'(obs_seg), 32'hFF);
        step();
        check_val("on0_seg",     32'(obs_seg), 32'hC0);
        check_val("on0_dig",     32'(obs_dig), 32'h01);
        run_to(16);
        check_val("slot1_idx",   32'(obs_slot), 32'd1);
        check_val("slot1_blank", 32'(obs_dig),  32'h00);
        run_to(0);
        check_val("frame_period", 32'(last_period), 32'd112);

        // mid-frame change stays invisible until the next snapshot
        run_to(40);
        dif.lower0001 = 8'h5B;
        run_to(85);
        check_val("old_l0001_seg", 32'(obs_seg), 32'hF9);
        check_val("old_l0001_dig", 32'(obs_dig), 32'h20);
        run_to(102);
        check_val("ann_seg", 32'(obs_seg), 32'hCE);
        check_val("ann_dig", 32'(obs_dig), 32'h40);
        run_to(85);
        check_val("new_l0001_seg", 32'(obs_seg), 32'hA4);

        // dim over one full frame
        run_to(111);
        dim = 1'b1;
        lit_cnt = 0;
        repeat (112) step();
        check_val("dim_lit_cycles", 32'(lit_cnt), 32'd49);
        check_val("dim_period",     32'(last_period), 32'd112);
        dim = 1'b0;

        // disable in slot 3 and re-enable
        run_to(50);
        en = 1'b0;
        step();
        check_val("dis_dig",  32'(obs_dig),  32'h00);
        check_val("dis_seg",  32'(obs_seg),  32'hFF);
        check_val("dis_slot", 32'(obs_slot), 32'd0);
        step();
        en = 1'b1;
        step();
        check_val("reen_fs", 32'(obs_fs), 32'd1);
        step();
        step();
        check_val("reen_dig", 32'(obs_dig), 32'h01);
        check_val("reen_seg", 32'(obs_seg), 32'hC0);

        // reset mid-ON
        run_to(20);
        reset = 1'b0;
        step();
        check_val("mrst_seg", 32'(obs_seg), 32'hFF);
        check_val("mrst_dig", 32'(obs_dig), 32'h00);
        check_val("mrst_fs",  32'(obs_fs),  32'd0);
        reset = 1'b1;
        step();
        check_val("mrst_restart_fs", 32'(obs_fs), 32'd1);
        step();
        step();
        check_val("mrst_restart_dig", 32'(obs_dig), 32'h01);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
